// File: rtl/usr_seq.sv
// ----------------------------------------------------------------------------
// usr_seq -- command sequencer for the 4-bit universal shift register (usr).
//
// Takes one command at a time (CLEAR, LOAD, SHR n, SHL n) over a valid/ready
// handshake. It expands the command into the per-cycle mode / parallel data /
// serial bit pattern the register needs, then pulses done. Every output is
// registered.
//
// Ports
//   c          in   1  clock, rising edge
//   r          in   1  synchronous reset, active low
//   cmd_valid  in   1  command present
//   cmd_ready  out  1  idle and able to accept a command
//   cmd_op     in   2  00 CLEAR, 01 LOAD, 10 SHR, 11 SHL
//   cmd_data   in   4  LOAD word, or serial bits for SHR/SHL (bit 0 first)
//   cmd_cnt    in   3  shift count for SHR/SHL, saturates at CNT_MAX
//   s          out  2  register mode: 00 hold, 01 load, 10 shr, 11 shl
//   x          out  4  register parallel data
//   z          out  1  register serial input bit
//   busy       out  1  not idle (always the inverse of cmd_ready)
//   done       out  1  one-cycle pulse at command completion
// ----------------------------------------------------------------------------
module usr_seq #(
    parameter int unsigned CNT_MAX = 4
) (
    input  logic       c,
    input  logic       r,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [1:0] cmd_op,
    input  logic [3:0] cmd_data,
    input  logic [2:0] cmd_cnt,
    output logic [1:0] s,
    output logic [3:0] x,
    output logic       z,
    output logic       busy,
    output logic       done
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_SHIFT = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        OP_CLEAR = 2'b00,
        OP_LOAD  = 2'b01,
        OP_SHR   = 2'b10,
        OP_SHL   = 2'b11
    } op_t;

    localparam logic [2:0] CNT_SAT = 3'(CNT_MAX);

    state_t     r_state,  w_state;
    logic [3:0] r_sdata,  w_sdata;   // serial bits still to be sent, next at bit 0
    logic [2:0] r_cnt,    w_cnt;     // shift cycles remaining, including current
    logic [1:0] r_s,      w_s;
    logic [3:0] r_x,      w_x;
    logic       r_z,      w_z;
    logic       r_busy,   w_busy;
    logic       r_done,   w_done;
    logic       r_ready,  w_ready;

    op_t        w_op;
    logic [2:0] w_cnt_sat;
    logic       w_accept;

    assign w_op      = op_t'(cmd_op);
    assign w_cnt_sat = (cmd_cnt > CNT_SAT) ? CNT_SAT : cmd_cnt;
    assign w_accept  = cmd_valid && r_ready;

    // Next state and next registered outputs. The defaults describe a busy,
    // non-completing cycle with the register held; each state overrides only
    // what differs.
    always_comb begin
        w_state = r_state;
        w_sdata = r_sdata;
        w_cnt   = r_cnt;
        w_s     = 2'b00;
        w_x     = r_x;
        w_z     = 1'b0;
        w_busy  = 1'b1;
        w_done  = 1'b0;
        w_ready = 1'b0;

        unique case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    unique case (w_op)
                        OP_CLEAR: begin
                            w_state = ST_LOAD;
                            w_s     = 2'b01;
                            w_x     = '0;
                        end
                        OP_LOAD: begin
                            w_state = ST_LOAD;
                            w_s     = 2'b01;
                            w_x     = cmd_data;
                        end
                        OP_SHR, OP_SHL: begin
                            if (w_cnt_sat == 3'd0) begin
                                w_state = ST_DONE;
                                w_done  = 1'b1;
                            end else begin
                                // First shift cycle is emitted straight from the
                                // handshake edge, so bit 0 goes out now and the
                                // remaining bits are kept pre-shifted.
                                w_state = ST_SHIFT;
                                w_s     = (w_op == OP_SHR) ? 2'b10 : 2'b11;
                                w_z     = cmd_data[0];
                                w_sdata = {1'b0, cmd_data[3:1]};
                                w_cnt   = w_cnt_sat;
                            end
                        end
                        default: ;
                    endcase
                end else begin
                    w_busy  = 1'b0;
                    w_ready = 1'b1;
                end
            end

            ST_LOAD: begin
                w_state = ST_DONE;
                w_done  = 1'b1;
            end

            ST_SHIFT: begin
                if (r_cnt == 3'd1) begin
                    w_state = ST_DONE;
                    w_done  = 1'b1;
                end else begin
                    w_cnt   = r_cnt - 3'd1;
                    w_s     = r_s;
                    w_z     = r_sdata[0];
                    w_sdata = {1'b0, r_sdata[3:1]};
                end
            end

            ST_DONE: begin
                w_state = ST_IDLE;
                w_busy  = 1'b0;
                w_ready = 1'b1;
            end

            default: begin
                w_state = ST_IDLE;
                w_busy  = 1'b0;
                w_ready = 1'b1;
            end
        endcase
    end

    always_ff @(posedge c) begin
        if (!r) begin
            r_state <= ST_IDLE;
            r_sdata <= '0;
            r_cnt   <= '0;
            r_s     <= '0;
            r_x     <= '0;
            r_z     <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_ready <= 1'b1;
        end else begin
            r_state <= w_state;
            r_sdata <= w_sdata;
            r_cnt   <= w_cnt;
            r_s     <= w_s;
            r_x     <= w_x;
            r_z     <= w_z;
            r_busy  <= w_busy;
            r_done  <= w_done;
            r_ready <= w_ready;
        end
    end

    assign cmd_ready = r_ready;
    assign s         = r_s;
    assign x         = r_x;
    assign z         = r_z;
    assign busy      = r_busy;
    assign done      = r_done;

endmodule
